// File: rtl/ls_pkg.sv
// ls_pkg: shared types and helpers for the MEM-stage load/store unit.
//   - access width encodings (W_BYTE, W_HALF, W_WORD; width[1]=1 means word)
//   - FSM state enum
//   - response error codes
//   - registered request struct
//   - nbytes(): access size in bytes for a width code
package ls_pkg;

    localparam logic [1:0] W_BYTE = 2'b00;
    localparam logic [1:0] W_HALF = 2'b01;
    localparam logic [1:0] W_WORD = 2'b10;

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_RANGE = 2'b01;
    localparam logic [1:0] ERR_ALIGN = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_e;

    typedef struct packed {
        logic        we;
        logic [1:0]  width;
        logic        sign;
        logic [31:0] addr;
        logic [31:0] wdata;
    } ls_req_t;

    // Any width code with bit 1 set is a word access.
    function automatic logic [2:0] nbytes(input logic [1:0] width);
        if (width[1])      return 3'd4;
        else if (width[0]) return 3'd2;
        else               return 3'd1;
    endfunction

endpackage

// File: rtl/ls_addr_check.sv
// ls_addr_check: combinational range / alignment check of a request address
// against the data RAM window [BASE, BASE+LENGTH).
//   addr_i  : full byte address
//   width_i : access width code
//   err_o   : ERR_OK, ERR_RANGE or ERR_ALIGN (range has priority)
// Optional feature macro: ALIGN_CHECK_EN enables the misalignment check;
// without it ERR_ALIGN is never produced.
module ls_addr_check
    import ls_pkg::*;
#(
    parameter logic [31:0] BASE   = 32'h1001_0000,
    parameter int unsigned LENGTH = 1024
) (
    input  logic [31:0] addr_i,
    input  logic [1:0]  width_i,
    output logic [1:0]  err_o
);

    logic [31:0] off;
    logic [32:0] end_excl;
    logic        range_ok;
    logic        align_ok;

    // Subtraction wraps, so addresses below BASE become huge offsets; the
    // end bound is formed in 33 bits so it cannot wrap back into range.
    assign off      = addr_i - BASE;
    assign end_excl = {1'b0, off} + {30'd0, nbytes(width_i)};
    assign range_ok = (end_excl <= 33'(LENGTH));

`ifdef ALIGN_CHECK_EN
    always_comb begin
        align_ok = 1'b1;
        if (width_i[1])      align_ok = (addr_i[1:0] == 2'b00);
        else if (width_i[0]) align_ok = ~addr_i[0];
    end
`else
    assign align_ok = 1'b1;
`endif

    always_comb begin
        err_o = ERR_OK;
        if (!range_ok)      err_o = ERR_RANGE;
        else if (!align_ok) err_o = ERR_ALIGN;
    end

endmodule

// File: rtl/ls_unit.sv
// ls_unit: MEM-stage load/store initiator. Accepts one request at a time,
// range-checks it, drives the data RAM port for exactly one cycle (ISSUE)
// and returns registered load data or a store ack via valid/ready.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   req_*                    : request handshake + payload (tag returned as-is)
//   resp_*                   : response handshake, data, tag, error code
//   mem_*                    : data RAM port, active only in ISSUE
//   mem_rdata                : RAM combinational read data, already extended
// Optional feature macro: ALIGN_CHECK_EN (misaligned half/word -> err 10,
// no RAM access). Default build issues misaligned accesses unchanged.
module ls_unit
    import ls_pkg::*;
#(
    parameter logic [31:0] BASE   = 32'h1001_0000,
    parameter int unsigned LENGTH = 1024,
    parameter int unsigned TAG_W  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [1:0]       req_width,
    input  logic             req_sign,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    input  logic [TAG_W-1:0] req_tag,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_data,
    output logic [TAG_W-1:0] resp_tag,
    output logic [1:0]       resp_err,
    output logic             mem_ena,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [1:0]       mem_width,
    output logic             mem_sign,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata
);

    state_e           state_q, state_d;
    ls_req_t          req_q, req_d;
    logic [31:0]      resp_data_q, resp_data_d;
    logic [TAG_W-1:0] resp_tag_q, resp_tag_d;
    logic [1:0]       resp_err_q, resp_err_d;
    logic [1:0]       chk_err;
    logic             issue;

    ls_addr_check #(
        .BASE   (BASE),
        .LENGTH (LENGTH)
    ) u_chk (
        .addr_i  (req_addr),
        .width_i (req_width),
        .err_o   (chk_err)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_q       <= '0;
            resp_data_q <= '0;
            resp_tag_q  <= '0;
            resp_err_q  <= ERR_OK;
        end else begin
            req_q       <= req_d;
            resp_data_q <= resp_data_d;
            resp_tag_q  <= resp_tag_d;
            resp_err_q  <= resp_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        resp_data_d = resp_data_q;
        resp_tag_d  = resp_tag_q;
        resp_err_d  = resp_err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    req_d.we    = req_we;
                    req_d.width = req_width;
                    req_d.sign  = req_sign;
                    req_d.addr  = req_addr;
                    req_d.wdata = req_wdata;
                    resp_tag_d  = req_tag;
                    resp_err_d  = chk_err;
                    resp_data_d = '0;
                    // Failed checks skip the RAM and respond next cycle.
                    state_d     = (chk_err == ERR_OK) ? S_ISSUE : S_RESP;
                end
            end
            S_ISSUE: begin
                resp_data_d = req_q.we ? 32'd0 : mem_rdata;
                state_d     = S_RESP;
            end
            S_RESP: begin
                if (resp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign resp_data  = resp_data_q;
    assign resp_tag   = resp_tag_q;
    assign resp_err   = resp_err_q;

    // RAM port is a pure decode of registered state: zero outside ISSUE.
    assign issue     = (state_q == S_ISSUE);
    assign mem_ena   = issue;
    assign mem_we    = issue & req_q.we;
    assign mem_addr  = issue ? req_q.addr  : 32'd0;
    assign mem_width = issue ? req_q.width : 2'b00;
    assign mem_sign  = issue & req_q.sign;
    assign mem_wdata = issue ? req_q.wdata : 32'd0;

endmodule
